mult_seq: RTL and testbench



---
 rtl/mult_seq_pkg.sv | 14 +
 rtl/mult_seq_if.sv | 27 ++
 rtl/mult_seq_adder_w.sv | 33 +++
 rtl/mult_seq.sv | 123 ++++++++++++
 tb/tb_mult_seq.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mult_seq_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// default widths and the controller state encoding.
package mult_seq_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2
  } state_t;

endpackage

// File: rtl/mult_seq_if.sv
// Start/busy/done handshake plus operand and product buses of the multiplier.
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic             sgn;
  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] tg;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, sgn, sr, tg,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, sgn, sr, tg,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_seq_adder_w.sv
// WIDTH-bit ripple-carry adder built from one-bit full-adder cells.
module adder_w
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_fa
    logic ci;
    logic co;
    logic axb;

    // Each cell owns its carry so the chain is a set of distinct nets
    if (gi == 0) begin : g_first
      assign ci = cin;
    end else begin : g_rest
      assign ci = g_fa[gi-1].co;
    end

    assign axb     = a[gi] ^ b[gi];
    assign sum[gi] = axb ^ ci;
    assign co      = (a[gi] & b[gi]) | (axb & ci);
  end

  assign cout = g_fa[WIDTH-1].co;

endmodule

// File: rtl/mult_seq.sv
// Multi-cycle shift-and-add multiplier for MULT/MULTU: magnitudes are
// multiplied unsigned over WIDTH cycles, then the sign is applied in one fix-up cycle.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       rst,
  mult_seq_if.slave  bus
);

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic                 neg_q, neg_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     sr_mag, tg_mag;
  logic [WIDTH-1:0]     acc_sum;
  logic                 acc_c;
  logic [2*WIDTH-1:0]   p_neg;
  logic                 neg_cout;

  // The most negative value maps onto itself, which is its correct unsigned magnitude
  assign sr_mag = (bus.sgn && bus.sr[WIDTH-1]) ? (~bus.sr + WIDTH'(1)) : bus.sr;
  assign tg_mag = (bus.sgn && bus.tg[WIDTH-1]) ? (~bus.tg + WIDTH'(1)) : bus.tg;

  adder_w #(.WIDTH(WIDTH)) u_acc (
    .sum  (acc_sum),
    .cout (acc_c),
    .a    (p_q[2*WIDTH-1:WIDTH]),
    .b    (mcand_q),
    .cin  (1'b0)
  );

  adder_w #(.WIDTH(2*WIDTH)) u_neg (
    .sum  (p_neg),
    .cout (neg_cout),
    .a    (~p_q),
    .b    ({(2*WIDTH){1'b0}}),
    .cin  (1'b1)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          mcand_d = sr_mag;
          p_d     = {{WIDTH{1'b0}}, tg_mag};
          neg_d   = bus.sgn & (bus.sr[WIDTH-1] ^ bus.tg[WIDTH-1]);
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (p_q[0]) begin
          p_d = {acc_c, acc_sum, p_q[WIDTH-1:1]};
        end else begin
          p_d = {1'b0, p_q[2*WIDTH-1:1]};
        end
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        // A carry out of the negation means P was zero, whose negation is P itself
        if (neg_q && !neg_cout) begin
          {hi_d, lo_d} = p_neg;
        end else begin
          {hi_d, lo_d} = p_q;
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != ST_IDLE);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq: directed vectors, handshake corner
// sequences and a randomized regression against a 64-bit arithmetic model.
module tb_mult_seq;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mult_seq_if #(.WIDTH(W)) bus ();

  mult_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] last_prod;

  typedef struct {
    string       name;
    logic        s;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb;
    logic [63:0] ua, ub;
    if (s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      return 64'(sa * sb);
    end
    ua = {32'd0, a};
    ub = {32'd0, b};
    return ua * ub;
  endfunction

  // Issues one operation and waits (bounded) for done; ends at the negedge where done=1.
  task automatic do_op(input logic s, input logic [31:0] a, input logic [31:0] b,
                       input bit no_wait, input int repulse_at,
                       output logic [63:0] prod, output int lat, output bit unstable);
    if (!no_wait) @(negedge clk);
    bus.start = 1'b1;
    bus.sgn   = s;
    bus.sr    = a;
    bus.tg    = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.sgn   = ~s;
    bus.sr    = $urandom;
    bus.tg    = $urandom;
    lat = 0;
    unstable = 1'b0;
    while (bus.done !== 1'b1 && lat < 60) begin
      if (bus.busy !== 1'b1 || {bus.hi, bus.lo} !== last_prod) unstable = 1'b1;
      bus.start = (repulse_at != 0 && lat == repulse_at);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
    prod = {bus.hi, bus.lo};
  endtask

  task automatic check_op(input string name, input logic [63:0] exp, input logic [63:0] prod,
                          input int lat, input bit unstable);
    chk({name, " product"}, prod, exp);
    chk({name, " latency"}, 64'(lat), 64'd33);
    chk({name, " busy at done"}, {63'd0, bus.busy}, 64'd0);
    chk({name, " busy/hold during op"}, {63'd0, unstable}, 64'd0);
    last_prod = exp;
  endtask

  initial begin
    logic [63:0] prod, exp;
    int          lat, pulses;
    bit          unst;
    logic        s;
    logic [31:0] a, b;

    vecs[0] = '{"u 3*5",          1'b0, 32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{"u max*max",      1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
    vecs[2] = '{"s -1*-1",        1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[3] = '{"s -3*7",         1'b1, 32'hFFFF_FFFD, 32'h0000_0007, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[4] = '{"s min*min",      1'b1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[5] = '{"u 2^31*2^31",    1'b0, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[6] = '{"u 0*0",          1'b0, 32'h0000_0000, 32'h0000_0000, 64'h0000_0000_0000_0000};
    vecs[7] = '{"s min*1",        1'b1, 32'h8000_0000, 32'h0000_0001, 64'hFFFF_FFFF_8000_0000};
    vecs[8] = '{"s maxpos*min",   1'b1, 32'h7FFF_FFFF, 32'h8000_0000, 64'hC000_0000_8000_0000};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.sgn = 1'b0;
    bus.sr = '0;
    bus.tg = '0;
    last_prod = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset busy", {63'd0, bus.busy}, 64'd0);
    chk("reset done", {63'd0, bus.done}, 64'd0);
    chk("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
    $display("reset: busy=%0d done=%0d hi=%h lo=%h", bus.busy, bus.done, bus.hi, bus.lo);

    for (int i = 0; i < 9; i++) begin
      do_op(vecs[i].s, vecs[i].a, vecs[i].b, 1'b0, 0, prod, lat, unst);
      check_op(vecs[i].name, vecs[i].exp, prod, lat, unst);
      $display("vec %s: sgn=%0d sr=%h tg=%h -> %h lat=%0d", vecs[i].name, vecs[i].s,
               vecs[i].a, vecs[i].b, prod, lat);
      @(negedge clk);
      chk({vecs[i].name, " done one cycle"}, {63'd0, bus.done}, 64'd0);
    end

    // start re-pulsed mid-operation must be ignored
    do_op(1'b0, 32'h0000_1234, 32'h0000_0010, 1'b0, 9, prod, lat, unst);
    check_op("restart ignored", 64'h0000_0000_0001_2340, prod, lat, unst);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("restart extra done", 64'(pulses), 64'd0);
    chk("restart hold", {bus.hi, bus.lo}, 64'h0000_0000_0001_2340);
    $display("restart-ignored: result=%h lat=%0d extra_done=%0d", prod, lat, pulses);

    // start in the done cycle is accepted
    do_op(1'b1, 32'hFFFF_FFF6, 32'h0000_000B, 1'b0, 0, prod, lat, unst);
    check_op("pre-chain", 64'hFFFF_FFFF_FFFF_FF92, prod, lat, unst);
    do_op(1'b0, 32'd100, 32'd200, 1'b1, 0, prod, lat, unst);
    check_op("start on done", 64'd20000, prod, lat, unst);
    $display("start-on-done: result=%h lat=%0d", prod, lat);

    // reset mid-operation discards the result
    @(negedge clk);
    bus.start = 1'b1;
    bus.sgn = 1'b0;
    bus.sr = 32'd9;
    bus.tg = 32'd9;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (18) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mid-rst busy", {63'd0, bus.busy}, 64'd0);
    chk("mid-rst done", {63'd0, bus.done}, 64'd0);
    chk("mid-rst hi/lo", {bus.hi, bus.lo}, 64'd0);
    last_prod = '0;
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) pulses++;
    end
    chk("mid-rst no done", 64'(pulses), 64'd0);
    do_op(1'b0, 32'd6, 32'd7, 1'b0, 0, prod, lat, unst);
    check_op("post-rst 6*7", 64'd42, prod, lat, unst);
    $display("mid-reset: after-rst done_pulses=%0d then 6*7=%h", pulses, prod);

    for (int i = 0; i < 1000; i++) begin
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 7))
        0: a = 32'h8000_0000;
        1: a = 32'hFFFF_FFFF;
        2: a = 32'h0000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'h8000_0000;
        1: b = 32'h7FFF_FFFF;
        2: b = 32'h0000_0001;
        default: b = $urandom;
      endcase
      exp = ref_mul(s, a, b);
      do_op(s, a, b, 1'($urandom_range(0, 1)), 0, prod, lat, unst);
      check_op($sformatf("rand %0d", i), exp, prod, lat, unst);
      $display("rand %0d: sgn=%0d sr=%h tg=%h -> %h exp %h", i, s, a, b, prod, exp);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
